hangman_game_ctrl: RTL
======================

Name: hangman_game_ctrl

Overview:
- Host-side game sequencer for a Wireless Hangman round.
- Latches the 5-letter secret word when the host toggles start.
- Accepts guess bytes from the UART receiver via a level `ready`. Per guess it reveals matching positions, counts misses and flags repeat or illegal guesses.
- Declares win or loss and drives the status LEDs, plus a display-refresh pulse for the host display formatter.

Parameters:
- MAX_MISTAKES, 6, wrong guesses that end the round as a loss (1..7).
- ERR_HOLD, 100, clk cycles `err_LED` stays high after an error event (≥1).

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- toggle_state  in  1  host start/new-word request; rising edge is the event
- setWord  in  40  secret word, 5 ASCII chars; char i = setWord[8i+7:8i], i=4 is leftmost
- msg  in  8  guessed ASCII char from the UART receiver
- ready  in  1  receiver data-valid level; held ≥2 cycles; rising edge is the event
- letter_mask  out  5  bit i = 1 when char i is revealed
- mistakes  out  3  wrong-guess count
- last_guess  out  8  most recently accepted guess char
- err_LED  out  1  repeat, illegal or bad-word indication
- blue  out  1  round in progress
- green  out  1  win
- red  out  1  loss
- game_end  out  1  one-cycle pulse on entering WIN or LOSE
- disp_update  out  1  one-cycle pulse whenever mask, mistakes, last_guess or the state change

Behaviour:
- All outputs registered.
- Reset (async, nRst=0) clears every output and internal register to 0: mask, mistakes, last_guess, 26-bit used-letter vector, err counter, edge detectors. State returns to IDLE.
- Edge detect: `ready` and `toggle_state` are registered each cycle. An event is `sig & ~sig_q`.
- States: IDLE, PLAY, CHECK, WIN, LOSE.
- IDLE:
  - On a toggle event, validate setWord: all 5 chars must be in 0x41–0x5A.
  - Valid: latch word, clear mask/mistakes/used/last_guess, go to PLAY, pulse disp_update.
  - Invalid: stay in IDLE, start err hold.
- PLAY:
  - blue=1.
  - On a ready event, latch msg into guess_reg and go to CHECK.
  - On a toggle event, abort the round and restart exactly as the IDLE valid/invalid path. Invalid word goes to IDLE.
  - Toggle and ready events in the same cycle: toggle wins, guess dropped.
- CHECK (exactly 1 cycle), evaluated in this priority order:
  1. msg not in 0x41–0x5A → err hold; mistakes, mask and used unchanged.
  2. used[msg-0x41]=1 (repeat) → err hold; no mistake counted.
  3. Otherwise set used bit and last_guess. Any char matching → OR all matching positions into mask. No match → mistakes+1.
  - Always pulse disp_update.
  - Next state: WIN if the new mask = 5'b11111; else LOSE if the new mistakes = MAX_MISTAKES; else PLAY.
  - Latency: ready rise sampled at edge N, state=CHECK after N, outputs updated after edge N+1.
- WIN: green=1, blue=0.
- LOSE: red=1, blue=0.
- game_end pulses high for exactly the first cycle in WIN or LOSE.
- WIN/LOSE hold until a toggle event, which restarts as in IDLE. Ready events are ignored.
- err hold:
  - err_LED=1 for ERR_HOLD cycles, starting the cycle after the error.
  - A new error reloads the counter.
- mistakes saturates at MAX_MISTAKES and never wraps.
- At most one of red, green, blue is high at any time.
- Mid-round reset: immediate clear to IDLE. A pending guess is discarded.

Test Plan:
- Reset then idle → all outputs 0, state IDLE. ready pulses with no toggle → no change, no disp_update.
- Word "MOORE" (0x4D4F4F5245), toggle → blue=1. Guesses:
  - O → mask=01100.
  - P → mistakes=1.
  - M → 11100.
  - M again → err_LED high for 100 cycles, mistakes=1.
  - R → 11110.
  - E → mask=11111, green=1, game_end pulse 1 cycle.
- Word "YUMMY" (0x59554D4D59), guesses I, L, K, N, J, F → mistakes 1..6; after F red=1, blue=0, game_end pulse, mask=00000. A further ready event → no change.
- Guess 0x61 ('a') or 0x31 in PLAY → err_LED=1, mistakes and mask unchanged, disp_update pulse.
- Word containing 0x20, toggle → stays IDLE with err_LED=1. Then a valid word plus toggle → PLAY.
- "YUMMY", guesses I and L (mistakes=2), then nRst low 1 cycle mid-CHECK → all outputs 0, IDLE. A following toggle starts a fresh round with mistakes=0.

Source files
------------

// File: rtl/hangman_game_ctrl.sv
// Hangman round sequencer: latches the secret word, scores guesses, and drives status LEDs and display pulses.
// All outputs are registered; a guess resolves one cycle after its ready edge, and inputs are never back-pressured.
module hangman_game_ctrl #(
  parameter int MAX_MISTAKES = 6,
  parameter int ERR_HOLD     = 100
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        toggle_state,
  input  logic [39:0] setWord,
  input  logic [7:0]  msg,
  input  logic        ready,
  output logic [4:0]  letter_mask,
  output logic [2:0]  mistakes,
  output logic [7:0]  last_guess,
  output logic        err_LED,
  output logic        blue,
  output logic        green,
  output logic        red,
  output logic        game_end,
  output logic        disp_update
);

  localparam int          CW    = $clog2(ERR_HOLD + 1);
  localparam logic [2:0]  MAX_M = 3'(MAX_MISTAKES);

  typedef enum logic [2:0] {IDLE, PLAY, CHECK, WIN, LOSE} state_t;

  state_t          state, state_nx;
  logic            tog_q, rdy_q, tog_ev, rdy_ev;
  logic [39:0]     word, word_nx;
  logic [7:0]      guess, guess_nx;
  logic [25:0]     used, used_nx;
  logic [4:0]      mask_nx, hit, gidx;
  logic [2:0]      mis_nx;
  logic [7:0]      last_nx;
  logic [CW-1:0]   err_cnt, err_cnt_nx;
  logic            err_ev, start, word_ok;
  logic            err_led_nx, blue_nx, green_nx, red_nx, game_end_nx, disp_nx;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  assign tog_ev = toggle_state & ~tog_q;
  assign rdy_ev = ready & ~rdy_q;
  // 'A'..'Z' have low five bits 1..26, so this is the alphabet index for legal guesses
  assign gidx   = guess[4:0] - 5'd1;

  always_comb begin
    hit     = '0;
    word_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hit[i]  = (word[8*i +: 8] == guess);
      word_ok = word_ok & is_upper(setWord[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    word_nx  = word;
    guess_nx = guess;
    used_nx  = used;
    mask_nx  = letter_mask;
    mis_nx   = mistakes;
    last_nx  = last_guess;
    err_ev   = 1'b0;
    start    = 1'b0;

    case (state)
      CHECK: begin
        if (!is_upper(guess)) begin
          err_ev = 1'b1;
        end else if (used[gidx]) begin
          err_ev = 1'b1;
        end else begin
          used_nx[gidx] = 1'b1;
          last_nx       = guess;
          if (|hit)                  mask_nx = letter_mask | hit;
          else if (mistakes < MAX_M) mis_nx  = mistakes + 3'd1;
        end
        if (mask_nx == 5'b11111) state_nx = WIN;
        else if (mis_nx == MAX_M) state_nx = LOSE;
        else                      state_nx = PLAY;
      end
      IDLE, PLAY, WIN, LOSE: begin
        // a toggle outranks a simultaneous guess, which is dropped
        if (tog_ev) begin
          if (word_ok) begin
            start = 1'b1;
          end else begin
            err_ev   = 1'b1;
            state_nx = IDLE;
          end
        end else if (state == PLAY && rdy_ev) begin
          guess_nx = msg;
          state_nx = CHECK;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start) begin
      word_nx  = setWord;
      used_nx  = '0;
      mask_nx  = '0;
      mis_nx   = '0;
      last_nx  = '0;
      state_nx = PLAY;
    end

    err_cnt_nx  = err_ev ? CW'(ERR_HOLD) : ((err_cnt != '0) ? err_cnt - 1'b1 : '0);
    err_led_nx  = err_ev | (err_cnt > CW'(1));
    blue_nx     = (state_nx == PLAY) || (state_nx == CHECK);
    green_nx    = (state_nx == WIN);
    red_nx      = (state_nx == LOSE);
    game_end_nx = ((state_nx == WIN) || (state_nx == LOSE)) && !((state == WIN) || (state == LOSE));
    disp_nx     = start || (state_nx != state) || (mask_nx != letter_mask) ||
                  (mis_nx != mistakes) || (last_nx != last_guess);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tog_q       <= 1'b0;
      rdy_q       <= 1'b0;
      word        <= '0;
      guess       <= '0;
      used        <= '0;
      err_cnt     <= '0;
      letter_mask <= '0;
      mistakes    <= '0;
      last_guess  <= '0;
      err_LED     <= 1'b0;
      blue        <= 1'b0;
      green       <= 1'b0;
      red         <= 1'b0;
      game_end    <= 1'b0;
      disp_update <= 1'b0;
    end else begin
      tog_q       <= toggle_state;
      rdy_q       <= ready;
      word        <= word_nx;
      guess       <= guess_nx;
      used        <= used_nx;
      err_cnt     <= err_cnt_nx;
      letter_mask <= mask_nx;
      mistakes    <= mis_nx;
      last_guess  <= last_nx;
      err_LED     <= err_led_nx;
      blue        <= blue_nx;
      green       <= green_nx;
      red         <= red_nx;
      game_end    <= game_end_nx;
      disp_update <= disp_nx;
    end
  end

endmodule
